// File: rtl/fma16_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fma16_issue_ctrl
//   Issue/retire controller wrapped around the combinational fma16 datapath.
//   A request is accepted over a valid/ready handshake, its opcode is decoded
//   into fma16's mul/add/negr/negz controls, and operands are held stable for
//   CORE_LAT extra cycles. fma16's result is then captured into a small
//   first-word-fall-through FIFO that is drained by a second handshake.
//
// Ports:
//   clk, reset_n                    clock, synchronous active-low reset
//   in_valid/in_ready               request handshake
//   in_op, in_x/y/z, in_rm, in_tag  request opcode, fp16 operands, rounding
//                                   mode and identifier
//   fma_x/y/z, fma_mul/add/negr/negz, fma_roundmode
//                                   registered drive into fma16
//   fma_result                      fma16 result (combinational from fma_*)
//   out_valid/out_ready             response handshake (FIFO head)
//   out_result, out_tag, out_err    head entry
//   ops_done                        count of popped responses (wraps)
// -----------------------------------------------------------------------------
module fma16_issue_ctrl #(
    parameter int CORE_LAT = 1,
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [15:0]      in_x,
    input  logic [15:0]      in_y,
    input  logic [15:0]      in_z,
    input  logic [1:0]       in_rm,
    input  logic [TAG_W-1:0] in_tag,
    output logic [15:0]      fma_x,
    output logic [15:0]      fma_y,
    output logic [15:0]      fma_z,
    output logic             fma_mul,
    output logic             fma_add,
    output logic             fma_negr,
    output logic             fma_negz,
    output logic [1:0]       fma_roundmode,
    input  logic [15:0]      fma_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [15:0]      ops_done
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

    state_t             state, state_nxt;
    logic [3:0]         wait_cnt;
    logic [TAG_W-1:0]   tag_p0;
    logic               err_p0;
    logic               accept;
    logic [4:0]         dec;

    logic [15:0]        res_mem [DEPTH];
    logic [TAG_W-1:0]   tag_mem [DEPTH];
    logic               err_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push, pop;

    // {err, mul, add, negr, negz}
    function automatic logic [4:0] decode_op(input logic [2:0] op);
        case (op)
            3'b000:  decode_op = 5'b0_0100;
            3'b001:  decode_op = 5'b0_0101;
            3'b010:  decode_op = 5'b0_1000;
            3'b011:  decode_op = 5'b0_1100;
            3'b100:  decode_op = 5'b0_1101;
            3'b101:  decode_op = 5'b0_1110;
            3'b110:  decode_op = 5'b0_1111;
            default: decode_op = 5'b1_0000;
        endcase
    endfunction

    assign in_ready = (state == IDLE) && (count < CNT_W'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign dec      = decode_op(in_op);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (CORE_LAT > 0) ? WAIT : CAPTURE;
            WAIT:    if (wait_cnt <= 4'd1) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n)           wait_cnt <= 4'd0;
        else if (accept)        wait_cnt <= 4'(CORE_LAT);
        else if (state == WAIT) wait_cnt <= wait_cnt - 4'd1;
    end

    // ---- issue stage: operands and controls held for fma16 until capture ----
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fma_x         <= '0;
            fma_y         <= '0;
            fma_z         <= '0;
            fma_roundmode <= '0;
            fma_mul       <= 1'b0;
            fma_add       <= 1'b0;
            fma_negr      <= 1'b0;
            fma_negz      <= 1'b0;
            tag_p0        <= '0;
            err_p0        <= 1'b0;
        end else if (accept) begin
            fma_x         <= in_x;
            fma_y         <= in_y;
            fma_z         <= in_z;
            fma_roundmode <= in_rm;
            fma_mul       <= dec[3];
            fma_add       <= dec[2];
            fma_negr      <= dec[1];
            fma_negz      <= dec[0];
            tag_p0        <= in_tag;
            err_p0        <= dec[4];
        end
    end

    // ---- retire stage: result FIFO ----
    // Only one op is ever in flight and acceptance needs a free slot, so a
    // push can never meet a full FIFO.
    assign push      = (state == CAPTURE);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            res_mem[wr_ptr] <= err_p0 ? 16'h7E00 : fma_result;
            tag_mem[wr_ptr] <= tag_p0;
            err_mem[wr_ptr] <= err_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ops_done <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                ops_done <= ops_done + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; gating by out_valid keeps the head at zero when empty.
    assign out_result = out_valid ? res_mem[rd_ptr] : 16'h0000;
    assign out_tag    = out_valid ? tag_mem[rd_ptr] : '0;
    assign out_err    = out_valid ? err_mem[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_fma16_issue_ctrl.sv
module tb_fma16_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_x, in_y, in_z;
    logic [1:0]  in_rm;
    logic [3:0]  in_tag;
    logic [15:0] fma_x, fma_y, fma_z;
    logic        fma_mul, fma_add, fma_negr, fma_negz;
    logic [1:0]  fma_roundmode;
    logic [15:0] fma_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_tag;
    logic        out_err;
    logic [15:0] ops_done;

    int checks   = 0;
    int failures = 0;
    int exp_done = 0;

    // Stub for the combinational core.
    assign fma_result = fma_x ^ fma_y ^ fma_z;

    always #5 clk = ~clk;

    fma16_issue_ctrl #(.CORE_LAT(1), .DEPTH(4), .TAG_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_rm(in_rm), .in_tag(in_tag),
        .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
        .fma_mul(fma_mul), .fma_add(fma_add), .fma_negr(fma_negr), .fma_negz(fma_negz),
        .fma_roundmode(fma_roundmode), .fma_result(fma_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_err(out_err), .ops_done(ops_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request for exactly one edge (caller ensures in_ready is high).
    task automatic issue(input logic [2:0] op, input logic [3:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_tag   = tag;
        tick();
        in_valid = 1'b0;
    endtask

    // Expected {mul,add,negr,negz} per opcode 0..6.
    logic [3:0] dec_tbl [7] = '{4'b0100, 4'b0101, 4'b1000, 4'b1100,
                                4'b1101, 4'b1110, 4'b1111};

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_tag = 4'd0;
        in_x = 16'h3C00; in_y = 16'h4000; in_z = 16'h4200; in_rm = 2'b01;
        out_ready = 1'b0;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_ops_done", 32'(ops_done), 0);
        chk("rst_fma_x", 32'(fma_x), 0);
        chk("rst_ctrl", 32'({fma_mul, fma_add, fma_negr, fma_negz}), 0);
        chk("rst_out_result", 32'(out_result), 0);
        reset_n = 1'b1;
        tick();

        // Decode sweep, responses drained immediately.
        out_ready = 1'b1;
        for (int op = 0; op < 7; op++) begin
            issue(3'(op), 4'(op));
            chk($sformatf("dec_ctrl_op%0d", op),
                32'({fma_mul, fma_add, fma_negr, fma_negz}), 32'(dec_tbl[op]));
            chk($sformatf("dec_rm_op%0d", op), 32'(fma_roundmode), 1);
            chk($sformatf("dec_busy_op%0d", op), 32'(in_ready), 0);
            tick(); tick();
            chk($sformatf("dec_res_op%0d", op), 32'(out_result), 32'h3E00);
            chk($sformatf("dec_tag_op%0d", op), 32'(out_tag), 32'(op));
            tick();
            exp_done++;
        end
        chk("dec_ops_done", 32'(ops_done), 32'(exp_done));

        // Latency: accept, then response two edges later.
        out_ready = 1'b0;
        issue(3'd3, 4'd3);
        chk("lat_t1_valid", 32'(out_valid), 0);
        tick();
        chk("lat_t2_valid", 32'(out_valid), 0);
        tick();
        chk("lat_t3_valid", 32'(out_valid), 1);
        chk("lat_result", 32'(out_result), 32'h3E00);
        chk("lat_tag", 32'(out_tag), 3);
        chk("lat_err", 32'(out_err), 0);
        out_ready = 1'b1; tick(); out_ready = 1'b0; exp_done++;
        chk("lat_drained", 32'(out_valid), 0);

        // Illegal opcode.
        issue(3'd7, 4'd5);
        chk("ill_ctrl", 32'({fma_mul, fma_add, fma_negr, fma_negz}), 0);
        tick(); tick();
        chk("ill_valid", 32'(out_valid), 1);
        chk("ill_result", 32'(out_result), 32'h7E00);
        chk("ill_err", 32'(out_err), 1);
        chk("ill_tag", 32'(out_tag), 5);
        out_ready = 1'b1; tick(); out_ready = 1'b0; exp_done++;

        // Backpressure: fill four entries, fifth request must stall.
        for (int t = 0; t < 4; t++) begin
            issue(3'd0, 4'(t));
            tick(); tick();
        end
        chk("bp_full_ready", 32'(in_ready), 0);
        in_valid = 1'b1; in_op = 3'd0; in_tag = 4'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stall_ready", 32'(in_ready), 0);
            chk("bp_head_stable", 32'(out_tag), 0);
        end
        out_ready = 1'b1;
        tick();                                   // pop tag 0
        chk("bp_pop1", 32'(out_tag), 1);
        chk("bp_ready_after_pop", 32'(in_ready), 1);
        tick();                                   // pop tag 1, accept tag 4
        in_valid = 1'b0;
        chk("bp_pop2", 32'(out_tag), 2);
        tick();                                   // pop tag 2
        chk("bp_pop3", 32'(out_tag), 3);
        tick();                                   // pop tag 3, push tag 4
        chk("bp_pop4", 32'(out_tag), 4);
        chk("bp_valid4", 32'(out_valid), 1);
        tick();                                   // pop tag 4
        chk("bp_empty", 32'(out_valid), 0);
        exp_done += 5;
        chk("bp_ops_done", 32'(ops_done), 32'(exp_done));

        // Simultaneous push and pop with one entry queued.
        out_ready = 1'b0;
        issue(3'd1, 4'd9);
        tick(); tick();
        issue(3'd1, 4'd10);
        tick();                                   // now in CAPTURE
        chk("pp_pre_count", 32'(dut.count), 1);
        out_ready = 1'b1;
        tick();
        chk("pp_count", 32'(dut.count), 1);
        chk("pp_valid", 32'(out_valid), 1);
        chk("pp_tag", 32'(out_tag), 10);
        tick();
        chk("pp_empty", 32'(out_valid), 0);
        exp_done += 2;
        chk("pp_ops_done", 32'(ops_done), 32'(exp_done));

        // Reset during WAIT with two entries queued.
        out_ready = 1'b0;
        issue(3'd2, 4'd6); tick(); tick();
        issue(3'd2, 4'd7); tick(); tick();
        issue(3'd2, 4'd8);                        // now in WAIT
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mr_valid", 32'(out_valid), 0);
        chk("mr_in_ready", 32'(in_ready), 1);
        chk("mr_ops_done", 32'(ops_done), 0);
        chk("mr_fma_x", 32'(fma_x), 0);
        chk("mr_ctrl", 32'({fma_mul, fma_add, fma_negr, fma_negz}), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mr_no_stale", 32'(out_valid), 0);
        end
        chk("mr_ops_done_end", 32'(ops_done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
